// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU op encodings, latencies and constants
package e_mdu_pkg;
  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8
  } md_op_e;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(5);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(10);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage MDU bus
// master drives: E_MDUOp, E_RS, E_RT, Req, D_IsMD
// slave drives:  Busy, MD_Stall, E_MDOut
interface e_mdu_if;
  import e_mdu_pkg::*;
  md_op_e E_MDUOp;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic Req;
  logic D_IsMD;
  logic Busy;
  logic MD_Stall;
  logic [31:0] E_MDOut;
  modport master(output E_MDUOp, E_RS, E_RT, Req, D_IsMD, input Busy, MD_Stall, E_MDOut);
  modport slave(input E_MDUOp, E_RS, E_RT, Req, D_IsMD, output Busy, MD_Stall, E_MDOut);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers
// ports: clk (rising edge), reset_n (async, active low), m (e_mdu_if.slave bus)
// option: MDU_DIVZERO_GUARD_EN makes divide-by-zero leave HI/LO unchanged
module e_mdu
  import e_mdu_pkg::*;
(
  input logic clk,
  input logic reset_n,
  e_mdu_if.slave m
);
  logic [31:0] hi, lo;
  logic [63:0] res, calc, prod_s, prod_u, dz_res;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [CNT_W-1:0] cnt;
  logic busy, is_div, is_start, start, div_zero, div_ovf;
  assign is_div = (m.E_MDUOp == DIV) | (m.E_MDUOp == DIVU);
  assign is_start = is_div | (m.E_MDUOp == MULT) | (m.E_MDUOp == MULTU);
  assign start = is_start & ~m.Req & ~busy;
  assign div_zero = m.E_RT == '0;
  assign div_ovf = (m.E_RS == INT_MIN) & (m.E_RT == ALL_ONES);
  assign prod_s = $signed({{32{m.E_RS[31]}}, m.E_RS}) * $signed({{32{m.E_RT[31]}}, m.E_RT});
  assign prod_u = {32'b0, m.E_RS} * {32'b0, m.E_RT};
  assign q_s = $signed(m.E_RS) / $signed(m.E_RT);
  assign r_s = $signed(m.E_RS) % $signed(m.E_RT);
  assign q_u = m.E_RS / m.E_RT;
  assign r_u = m.E_RS % m.E_RT;
`ifdef MDU_DIVZERO_GUARD_EN
  // HI/LO cannot change while busy, so writing them back is a no-op update
  assign dz_res = {hi, lo};
`else
  assign dz_res = {m.E_RS, ALL_ONES};
`endif
  // whole result is formed at start; the countdown only delays its retirement
  always_comb begin
    calc = m.E_MDUOp == MULT ? prod_s : m.E_MDUOp == MULTU ? prod_u : m.E_MDUOp == DIVU ? {r_u, q_u} : {r_s, q_s};
    if (is_div && div_zero) calc = dz_res;
    else if (m.E_MDUOp == DIV && div_ovf) calc = {32'b0, INT_MIN};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
      res <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      res <= calc;
      cnt <= is_div ? DIV_LAT : MULT_LAT;
      busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - CNT_LAST;
      if (cnt == CNT_LAST) begin
        busy <= 1'b0;
        {hi, lo} <= res;
      end
    end else if (!m.Req && m.E_MDUOp == MTHI) hi <= m.E_RS;
    else if (!m.Req && m.E_MDUOp == MTLO) lo <= m.E_RS;
  assign m.Busy = busy;
  // gated by reset_n so a start-class op held during reset never stalls
  assign m.MD_Stall = reset_n & m.D_IsMD & (start | busy);
  assign m.E_MDOut = m.E_MDUOp == MFHI ? hi : m.E_MDUOp == MFLO ? lo : '0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: table-driven self-checking bench for e_mdu (honours MDU_DIVZERO_GUARD_EN)
module tb_e_mdu;
  import e_mdu_pkg::*;
  typedef struct {
    md_op_e op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int fails = 0;
  vec_t tv[10];
  logic [31:0] h, l;
  e_mdu_if bus();
  e_mdu dut(.clk(clk), .reset_n(reset_n), .m(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt, input logic req, input logic is_md);
    bus.E_MDUOp = op;
    bus.E_RS = rs;
    bus.E_RT = rt;
    bus.Req = req;
    bus.D_IsMD = is_md;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic read_hl(output logic [31:0] rh, output logic [31:0] rl);
    drive(MFHI, 0, 0, 0, 0);
    #1 rh = bus.E_MDOut;
    drive(MFLO, 0, 0, 0, 0);
    #1 rl = bus.E_MDOut;
    drive(MD_NONE, 0, 0, 0, 0);
  endtask
  task automatic run(input vec_t v, input int idx);
    int n = 0;
    logic st_ok = 1'b1;
    logic [31:0] rh, rl;
    string nm = $sformatf("v%0d", idx);
    drive(v.op, v.rs, v.rt, 0, 1);
    #1 chk({nm, " start_stall"}, 32'(bus.MD_Stall), 1);
    step;
    drive(MD_NONE, 0, 0, 0, 1);
    while (bus.Busy === 1'b1 && n < 40) begin
      #1 st_ok &= bus.MD_Stall;
      step;
      n++;
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'(v.lat));
    chk({nm, " busy_stall"}, 32'(st_ok), 1);
    #1 chk({nm, " stall_after"}, 32'(bus.MD_Stall), 0);
    read_hl(rh, rl);
    chk({nm, " hi"}, rh, v.hi);
    chk({nm, " lo"}, rl, v.lo);
  endtask
  initial begin
    tv[0] = '{MULT,  32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tv[1] = '{MULTU, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA, 5};
    tv[2] = '{DIV,   32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tv[3] = '{DIVU,  32'd7,        32'd2,          32'd1,        32'd3,        10};
    tv[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000, 10};
`ifdef MDU_DIVZERO_GUARD_EN
    tv[5] = '{DIV,   32'd5,        32'd0,          32'd0,        32'h80000000, 10};
`else
    tv[5] = '{DIV,   32'd5,        32'd0,          32'd5,        32'hFFFFFFFF, 10};
`endif
    tv[6] = '{DIVU,  32'd100,      32'd7,          32'd2,        32'd14,       10};
    tv[7] = '{DIV,   32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD, 10};
    tv[8] = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001, 5};
    tv[9] = '{MULT,  32'h80000000, 32'h80000000,   32'h40000000, 32'h00000000, 5};
    drive(MULT, 2, 3, 0, 1);
    repeat (2) step;
    chk("rst busy", 32'(bus.Busy), 0);
    chk("rst stall", 32'(bus.MD_Stall), 0);
    read_hl(h, l);
    chk("rst hi", h, 0);
    chk("rst lo", l, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) run(tv[i], i);
    drive(MTHI, 32'h1234, 0, 0, 0);
    step;
    drive(MTLO, 32'h5678, 0, 0, 0);
    step;
    read_hl(h, l);
    chk("mthi", h, 32'h1234);
    chk("mtlo", l, 32'h5678);
    drive(MTHI, 32'hDEAD, 0, 1, 0);
    step;
    read_hl(h, l);
    chk("mthi req", h, 32'h1234);
    drive(DIV, 7, 2, 1, 1);
    #1 chk("div req stall", 32'(bus.MD_Stall), 0);
    step;
    chk("div req busy", 32'(bus.Busy), 0);
    read_hl(h, l);
    chk("div req hi", h, 32'h1234);
    chk("div req lo", l, 32'h5678);
    drive(MULTU, 6, 7, 0, 0);
    step;
    drive(MTLO, 32'hBAD, 0, 0, 0);
    step;
    drive(DIVU, 1, 1, 0, 0);
    step;
    drive(MD_NONE, 0, 0, 0, 0);
    repeat (5) step;
    chk("ign busy", 32'(bus.Busy), 0);
    read_hl(h, l);
    chk("ign hi", h, 0);
    chk("ign lo", l, 32'd42);
    drive(DIVU, 100, 7, 0, 0);
    step;
    drive(MD_NONE, 0, 0, 0, 0);
    repeat (2) step;
    chk("mid busy pre", 32'(bus.Busy), 1);
    reset_n = 1'b0;
    #1 chk("mid rst busy", 32'(bus.Busy), 0);
    read_hl(h, l);
    chk("mid rst hi", h, 0);
    chk("mid rst lo", l, 0);
    #1 reset_n = 1'b1;
    repeat (12) step;
    chk("mid after busy", 32'(bus.Busy), 0);
    read_hl(h, l);
    chk("mid after hi", h, 0);
    chk("mid after lo", l, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
